// File: rtl/instruction_encoder_if.sv
// Instruction-field stream into the encoder: one beat per accepted instruction.
// The producer drives the fields and in_valid; the encoder answers with in_ready.
interface instruction_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        last;

  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, target, last,
    input  in_ready
  );

  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, target, last,
    output in_ready
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs R/I/J instruction fields into 32-bit MIPS words, buffers them in a FIFO and
// writes them to consecutive instruction-memory addresses. Optional macro: FMT_CHECK_EN.
module instruction_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  instruction_encoder_if.slave  in_if,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_W:0]       count_o,
  output logic                  err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [31:0] encode(
    input logic [1:0]  fmt,
    input logic [5:0]  opcode,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    case (fmt)
      2'b01:   return {opcode, rs, rt, imm};
      2'b10:   return {opcode, target};
      default: return {opcode, rs, rt, rd, shamt, funct};
    endcase
  endfunction

  state_t            state_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W:0]   count_q;

  logic        fmt_bad;
  logic        accept;
  logic        push;
  logic        pop;
  logic        start_ok;
  logic [31:0] enc_word;

`ifdef FMT_CHECK_EN
  assign fmt_bad = (in_if.fmt == 2'b11);
`else
  assign fmt_bad = 1'b0;
`endif

  assign accept   = in_ready_q & in_if.in_valid;
  assign push     = accept & ~fmt_bad;
  assign pop      = (level_q != '0) & mem_ready_i;
  assign start_ok = start_i & (state_q == ST_IDLE);
  assign level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  assign enc_word = encode(in_if.fmt, in_if.opcode, in_if.rs, in_if.rt, in_if.rd,
                           in_if.shamt, in_if.funct, in_if.imm, in_if.target);

  // NOTE: storage has no reset; the level counter alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      mem_addr_q <= ADDR_BASE;
      count_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      // A session only starts with an empty FIFO, so start and pop never collide.
      if (start_ok) begin
        mem_addr_q <= ADDR_BASE;
        count_q    <= '0;
      end else if (pop) begin
        mem_addr_q <= mem_addr_q + ADDR_W'(1);
        if (count_q != COUNT_MAX) count_q <= count_q + (ADDR_W + 1)'(1);
      end
    end
  end

  // NOTE: non-blocking assignments everywhere below, so every branch sees the old state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q    <= ST_LOAD;
            busy_q     <= 1'b1;
            in_ready_q <= (level_d != LVL_FULL);
            err_q      <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept && fmt_bad) err_q <= 1'b1;
          if (accept && in_if.last) begin
            state_q    <= ST_DRAIN;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= (level_d != LVL_FULL);
          end
        end
        ST_DRAIN: begin
          if (level_q == '0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign mem_we_o       = (level_q != '0);
  assign mem_wdata_o    = (level_q != '0) ? fifo_q[rd_ptr_q] : 32'h0;
  assign mem_addr_o     = mem_addr_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign count_o        = count_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: a default instance (ADDR_W=8) and an ADDR_W=2
// instance share the same stimulus; writes are logged and compared to hand-computed words.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_ready = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  fmt = '0;
  logic [5:0]  opcode = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        last = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_encoder_if ifa ();
  instruction_encoder_if ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.fmt      = fmt;       assign ifb.fmt      = fmt;
  assign ifa.opcode   = opcode;    assign ifb.opcode   = opcode;
  assign ifa.rs       = rs;        assign ifb.rs       = rs;
  assign ifa.rt       = rt;        assign ifb.rt       = rt;
  assign ifa.rd       = rd;        assign ifb.rd       = rd;
  assign ifa.shamt    = shamt;     assign ifb.shamt    = shamt;
  assign ifa.funct    = funct;     assign ifb.funct    = funct;
  assign ifa.imm      = imm;       assign ifb.imm      = imm;
  assign ifa.target   = target;    assign ifb.target   = target;
  assign ifa.last     = last;      assign ifb.last     = last;

  logic        a_we, a_busy, a_done, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;
  logic        b_we, b_busy, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  instruction_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) ua (
    .clk(clk), .rst(rst), .start_i(start), .in_if(ifa.slave),
    .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_wdata_o(a_wdata), .mem_ready_i(mem_ready),
    .busy_o(a_busy), .done_o(a_done), .count_o(a_count), .err_o(a_err)
  );

  instruction_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) ub (
    .clk(clk), .rst(rst), .start_i(start), .in_if(ifb.slave),
    .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata), .mem_ready_i(mem_ready),
    .busy_o(b_busy), .done_o(b_done), .count_o(b_count), .err_o(b_err)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t wa[$];
  wr_t wb[$];

  // A write completes at the next rising edge when we && ready are seen here.
  always @(negedge clk) begin
    if (!rst && mem_ready) begin
      if (a_we) wa.push_back({a_addr, a_wdata});
      if (b_we) wb.push_back({6'b0, b_addr, b_wdata});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [7:0] exp_addr,
                          input logic [31:0] exp_data);
    logic [31:0] obs_a, obs_d;
    obs_a = (idx < wa.size()) ? {24'h0, wa[idx].addr} : 'x;
    obs_d = (idx < wa.size()) ? wa[idx].data : 'x;
    check({tag, "_addr"}, obs_a, {24'h0, exp_addr});
    check({tag, "_data"}, obs_d, exp_data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg,
                      input logic l);
    int n;
    fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh;
    funct = fn; imm = im; target = tg; last = l;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ifa.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifa.in_ready) check("accept_timeout", 32'(ifa.in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  task automatic send_j(input logic [25:0] tg, input logic l);
    send(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, tg, l);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(a_done), 32'h1);
    check({tag, "_busy_in_done"}, 32'(a_busy), 32'h0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(a_done), 32'h0);
    tick();
  endtask

  initial begin
    // Reset values
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(ifa.in_ready), 32'h0);
    check("rst_we",       32'(a_we),         32'h0);
    check("rst_addr",     32'(a_addr),       32'h0);
    check("rst_wdata",    a_wdata,           32'h0);
    check("rst_busy",     32'(a_busy),       32'h0);
    check("rst_done",     32'(a_done),       32'h0);
    check("rst_count",    32'(a_count),      32'h0);
    check("rst_err",      32'(a_err),        32'h0);
    tick();

    // Single R beat: add $3,$1,$2
    wa.delete();
    do_start();
    check("start_busy",     32'(a_busy),       32'h1);
    check("start_in_ready", 32'(ifa.in_ready), 32'h1);
    send(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF, 1'b1);
    check("r_latency_we",    32'(a_we), 32'h1);
    check("r_latency_wdata", a_wdata,   32'h00221820);
    wait_done("r");
    check("r_count", 32'(a_count), 32'd1);
    check("r_nwr",   wa.size(),    32'd1);
    check_wr("r_wr0", 0, 8'd0, 32'h00221820);

    // I beat (lw $8,4($29)) then J beat (j 0x10)
    wa.delete();
    do_start();
    send(2'b01, 6'h23, 5'd29, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004, 26'h0, 1'b0);
    send_j(26'h0000010, 1'b1);
    wait_done("ij");
    check("ij_count", 32'(a_count), 32'd2);
    check("ij_nwr",   wa.size(),    32'd2);
    check_wr("ij_wr0", 0, 8'd0, 32'h8FA80004);
    check_wr("ij_wr1", 1, 8'd1, 32'h08000010);

    // Back-pressure: 4 accepts fill the FIFO, the next beats wait for memory
    wa.delete();
    mem_ready = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) send_j(26'h100 + 26'(i), 1'b0);
    check("bp_full_in_ready", 32'(ifa.in_ready), 32'h0);
    check("bp_we",            32'(a_we),         32'h1);
    fmt = 2'b10; opcode = 6'h02; target = 26'h104; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_hold_in_ready", 32'(ifa.in_ready), 32'h0);
    check("bp_hold_addr",     32'(a_addr),       32'h0);
    check("bp_hold_wdata",    a_wdata,           32'h08000100);
    tick();
    mem_ready = 1'b1;
    send_j(26'h104, 1'b0);
    send_j(26'h105, 1'b1);
    wait_done("bp");
    check("bp_count", 32'(a_count), 32'd6);
    check("bp_nwr",   wa.size(),    32'd6);
    for (int i = 0; i < 6; i++)
      check_wr($sformatf("bp_wr%0d", i), i, 8'(i), 32'h08000100 + 32'(i));

    // Address wrap and count saturation on the ADDR_W=2 instance
    wa.delete();
    wb.delete();
    do_start();
    for (int i = 0; i < 5; i++) send_j(26'h200 + 26'(i), i == 4);
    wait_done("wrap");
    check("wrap_a_count", 32'(a_count), 32'd5);
    check("wrap_b_count", 32'(b_count), 32'd4);
    check("wrap_b_nwr",   wb.size(),    32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wrap_b_addr%0d", i),
            (i < wb.size()) ? {24'h0, wb[i].addr} : 'x, 32'(i % 4));
      check($sformatf("wrap_b_data%0d", i),
            (i < wb.size()) ? wb[i].data : 'x, 32'h08000200 + 32'(i));
    end

    // Reserved format in the middle of a session
    wa.delete();
    do_start();
    send(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
    send(2'b11, 6'h00, 5'd4, 5'd5, 5'd6, 5'd1, 6'h22, 16'h1234, 26'h0, 1'b0);
    send(2'b01, 6'h08, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b1);
    wait_done("fmt");
`ifdef FMT_CHECK_EN
    check("fmt_nwr", wa.size(), 32'd2);
    check("fmt_err", 32'(a_err), 32'h1);
    check_wr("fmt_wr0", 0, 8'd0, 32'h00221820);
    check_wr("fmt_wr1", 1, 8'd1, 32'h2021FFFF);
`else
    check("fmt_nwr", wa.size(), 32'd3);
    check("fmt_err", 32'(a_err), 32'h0);
    check_wr("fmt_wr0", 0, 8'd0, 32'h00221820);
    check_wr("fmt_wr1", 1, 8'd1, 32'h00853062);
    check_wr("fmt_wr2", 2, 8'd2, 32'h2021FFFF);
`endif

    // Reset with three words buffered
    wa.delete();
    mem_ready = 1'b0;
    do_start();
    check("restart_err", 32'(a_err), 32'h0);
    for (int i = 0; i < 3; i++) send_j(26'h300 + 26'(i), 1'b0);
    check("pre_rst_we", 32'(a_we), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_we",       32'(a_we),         32'h0);
    check("mid_rst_busy",     32'(a_busy),       32'h0);
    check("mid_rst_in_ready", 32'(ifa.in_ready), 32'h0);
    check("mid_rst_count",    32'(a_count),      32'h0);
    check("mid_rst_wdata",    a_wdata,           32'h0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    do_start();
    send_j(26'h3AB, 1'b1);
    wait_done("post_rst");
    check("post_rst_nwr",   wa.size(),    32'd1);
    check("post_rst_count", 32'(a_count), 32'd1);
    check_wr("post_rst_wr0", 0, 8'd0, 32'h080003AB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Sequential instruction encoder and program loader; the write-side counterpart of the instruction decode path. It accepts instruction descriptions field by field over a valid/ready handshake and packs each into a 32-bit MIPS word in R, I or J format. Encoded words are buffered in a small FIFO, then written to consecutive word addresses of the instruction memory. It is used at bring-up and by the bench to fill program memory before the core is released.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_W, 8: instruction-memory word-address width.
- BASE_ADDR, 0: first word address written in each load session.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a load session; honoured only in IDLE.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept.
- fmt  in  2  00 R, 01 I, 10 J, 11 reserved.
- opcode  in  6  bits [31:26].
- rs, rt, rd, shamt  in  5 each  register / shift fields.
- funct  in  6  R-format function field.
- imm  in  16  I-format immediate.
- target  in  26  J-format target.
- last  in  1  marks the final instruction of the session.
- mem_we  out  1  write request to instruction memory.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepts the write this cycle.
- busy  out  1  high in LOAD and DRAIN.
- done  out  1  one-cycle pulse at session end.
- count  out  ADDR_W+1  words written this session.
- err  out  1  sticky error flag.

## Operation
- Encoding:
  - R: {opcode, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, imm}.
  - J: {opcode, target}.
  - Unused fields are ignored.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: in_ready=0. On start: go to LOAD, set mem_addr=BASE_ADDR, count=0, err=0.
  - LOAD: in_ready = FIFO not full. An instruction is accepted when in_valid && in_ready; it is encoded and pushed. Accepting with last=1 goes to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Write side, active in all states:
  - mem_we = FIFO not empty; mem_wdata = FIFO head.
  - A write completes on mem_we && mem_ready. On completion: pop the FIFO, mem_addr+1 (wraps modulo 2^ADDR_W), count+1 (saturates at 2^ADDR_W).
  - mem_addr, mem_wdata and mem_we hold stable while mem_ready=0.
- A full FIFO deasserts in_ready even if a pop occurs the same cycle; no push-on-full.
- start outside IDLE is ignored.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, busy 0, done 0, count 0, err 0, FSM IDLE, FIFO empty.
- start sampled in cycle N → busy=1 and in_ready=1 in cycle N+1.
- Acceptance in cycle N into an empty FIFO → mem_we=1 with that word in cycle N+1.
- With mem_ready held high, sustained throughput is one word per cycle.
- DRAIN→DONE happens the cycle after the FIFO becomes empty. done pulses exactly one cycle; busy is already 0 during DONE.
- Reset mid-session: FIFO contents are discarded, no further writes occur, outputs return to reset values immediately.

## Configuration
- FMT_CHECK_EN defined:
  - fmt=11 still completes the handshake but is not pushed, and err is set (sticky until the next start).
  - last on such a beat still moves the FSM to DRAIN.
- FMT_CHECK_EN undefined:
  - fmt=11 is encoded as R format.
  - err is tied to 0.

## Test plan
- Reset, start, one R beat (opcode 0, rs 1, rt 2, rd 3, shamt 0, funct 0x20, last=1) → one write 0x00221820 at address BASE_ADDR; done pulses; count=1.
- Session with I beat (opcode 0x23, rs 29, rt 8, imm 0x0004) then J beat (opcode 0x02, target 0x0000010) → writes 0x8FA80004 at address 0 and 0x08000010 at address 1.
- mem_ready=0 while 6 beats are offered with DEPTH=4 → in_ready drops after 4 accepts; releasing mem_ready drains all 6 in order with no loss.
- ADDR_W=2, 5 beats → addresses 0,1,2,3,0; count saturates at 4.
- With FMT_CHECK_EN: beats R, fmt=11, I(last) → only 2 writes; err=1 until the next start.
- Assert reset with 3 words buffered → mem_we=0 next cycle; after a new start, the first write is at BASE_ADDR.
